c2f_chunk_drain: RTL

- Sits directly downstream of the TLP transceiver's CPU->FPGA burst pipe (chunk index, chunk offset, data, byte-enables, valid).
- Stores CPU-written QWs into a circular chunk RAM.
- Once the CPU commits chunks by advancing its write pointer, streams them out in order on a valid/ready QW stream.
- Publishes a read pointer so software knows which chunks it may overwrite.

---
 rtl/c2f_chunk_drain.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/c2f_chunk_drain.sv
// c2f_chunk_drain: circular chunk store for the CPU->FPGA burst pipe.
// CPU burst writes land in a byte-enabled RAM addressed {chunk, offset}.
// Chunks committed by the CPU write pointer are streamed out in order on a
// valid/ready QW stream, and the read pointer is published back to software.
//
// Ports:
//   clk_in, reset_n_in         clock, async active-low reset
//   c2fChunkIndex_in/Offset_in burst write address (chunk, QW offset)
//   c2fData_in, c2fBE_in       write data and per-byte enables
//   c2fValid_in                write strobe (always accepted)
//   c2fWrPtr_in                CPU commit pointer
//   c2fRdPtr_out               next chunk to drain
//   data_out/valid_out/ready_in/sop_out/eop_out  drained QW stream
//   err_out                    sticky protocol error (C2F_DRAIN_CHECK_EN only)
//
// Optional build macro: C2F_DRAIN_CHECK_EN adds write/commit protection and err_out.
module c2f_chunk_drain #(
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned OFFSET_WIDTH = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [INDEX_WIDTH-1:0]  c2fChunkIndex_in,
    input  logic [OFFSET_WIDTH-1:0] c2fChunkOffset_in,
    input  logic [63:0]             c2fData_in,
    input  logic [7:0]              c2fBE_in,
    input  logic                    c2fValid_in,
    input  logic [INDEX_WIDTH-1:0]  c2fWrPtr_in,
    output logic [INDEX_WIDTH-1:0]  c2fRdPtr_out,
    output logic [63:0]             data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    sop_out,
    output logic                    eop_out
`ifdef C2F_DRAIN_CHECK_EN
    ,
    output logic                    err_out
`endif
);

    localparam int unsigned ADDR_WIDTH = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = '1;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [63:0] data;
    } qw_t;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} drainState_e;

    logic [63:0]             mem [DEPTH];
    drainState_e             state, stateNext;
    logic [INDEX_WIDTH-1:0]  wrPtrReg, rdPtr, issuePtr, issuePtrNext;
    logic [OFFSET_WIDTH-1:0] issueOffset, issueOffsetNext;
    logic [ADDR_WIDTH-1:0]   issueAddr, wrAddr;
    logic                    issueRead, writeEn;
    logic                    rdValid, rdSop, rdEop;
    logic [63:0]             rdData;
    qw_t                     rdQw, skid0, skid1;
    logic [1:0]              skidCount;
    logic                    pop, room, pipeEmpty, issuePending;

    assign issueAddr    = {issuePtr, issueOffset};
    assign wrAddr       = {c2fChunkIndex_in, c2fChunkOffset_in};
    assign rdQw         = {rdSop, rdEop, rdData};
    assign valid_out    = (skidCount != 2'd0);
    assign data_out     = skid0.data;
    assign sop_out      = valid_out & skid0.sop;
    assign eop_out      = valid_out & skid0.eop;
    assign c2fRdPtr_out = rdPtr;
    assign pop          = valid_out & ready_in;
    // A read issued now lands in the skid next edge; only issue if it will fit.
    assign room         = (3'(skidCount) + 3'(rdValid)) <= (3'(pop) + 3'd1);
    assign pipeEmpty    = (skidCount == 2'd0) && !rdValid;
    // Issue side runs ahead of rdPtr so chunk boundaries stream without a bubble.
    assign issuePending = (wrPtrReg != issuePtr);

`ifdef C2F_DRAIN_CHECK_EN
    logic committedWr, wrPtrBackward;
    assign committedWr   = INDEX_WIDTH'(c2fChunkIndex_in - rdPtr) < INDEX_WIDTH'(wrPtrReg - rdPtr);
    assign wrPtrBackward = (c2fWrPtr_in != wrPtrReg) &&
                           (INDEX_WIDTH'(c2fWrPtr_in - rdPtr) < INDEX_WIDTH'(wrPtrReg - rdPtr));
    assign writeEn       = c2fValid_in & ~committedWr;

    // Sticky protocol error flag.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            err_out <= 1'b0;
        end else if ((c2fValid_in && committedWr) || wrPtrBackward) begin
            err_out <= 1'b1;
        end
    end
`else
    assign writeEn = c2fValid_in;
`endif

    // Chunk RAM: byte-enabled write, read-first synchronous read.
    always_ff @(posedge clk_in) begin
        if (writeEn) begin
            for (int b = 0; b < 8; b++) begin
                if (c2fBE_in[b]) begin
                    mem[wrAddr][8*b +: 8] <= c2fData_in[8*b +: 8];
                end
            end
        end
        if (issueRead) begin
            rdData <= mem[issueAddr];
        end
    end

    // Read FSM next-state and read issue.
    always_comb begin
        stateNext       = state;
        issueRead       = 1'b0;
        issuePtrNext    = issuePtr;
        issueOffsetNext = issueOffset;
        case (state)
            IDLE: begin
                if (issuePending) begin
                    issueRead       = 1'b1;
                    issueOffsetNext = OFFSET_WIDTH'(1);
                    stateNext       = STREAM;
                end
            end
            STREAM: begin
                if (room) begin
                    issueRead = 1'b1;
                    if (issueOffset == LAST_OFFSET) begin
                        issueOffsetNext = '0;
                        issuePtrNext    = issuePtr + INDEX_WIDTH'(1);
                        if (wrPtrReg == issuePtr + INDEX_WIDTH'(1)) begin
                            stateNext = FLUSH;
                        end
                    end else begin
                        issueOffsetNext = issueOffset + OFFSET_WIDTH'(1);
                    end
                end
            end
            FLUSH: begin
                // Last committed chunk issued; resume if more arrive, else drain out.
                if (issuePending) begin
                    if (room) begin
                        issueRead       = 1'b1;
                        issueOffsetNext = OFFSET_WIDTH'(1);
                        stateNext       = STREAM;
                    end
                end else if (pipeEmpty) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM state, pointers and RAM read pipeline tags.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= IDLE;
            issuePtr    <= '0;
            issueOffset <= '0;
            wrPtrReg    <= '0;
            rdPtr       <= '0;
            rdValid     <= 1'b0;
            rdSop       <= 1'b0;
            rdEop       <= 1'b0;
        end else begin
            state       <= stateNext;
            issuePtr    <= issuePtrNext;
            issueOffset <= issueOffsetNext;
            wrPtrReg    <= c2fWrPtr_in;
            rdValid     <= issueRead;
            rdSop       <= (issueOffset == '0);
            rdEop       <= (issueOffset == LAST_OFFSET);
            if (pop && skid0.eop) begin
                rdPtr <= rdPtr + INDEX_WIDTH'(1);
            end
        end
    end

    // Two-entry output skid buffer; skid0 is the head.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            skid0     <= '0;
            skid1     <= '0;
            skidCount <= 2'd0;
        end else begin
            case ({rdValid, pop})
                2'b10: begin
                    if (skidCount == 2'd0) skid0 <= rdQw;
                    else                   skid1 <= rdQw;
                    skidCount <= skidCount + 2'd1;
                end
                2'b01: begin
                    skid0     <= skid1;
                    skidCount <= skidCount - 2'd1;
                end
                2'b11: begin
                    if (skidCount == 2'd1) begin
                        skid0 <= rdQw;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= rdQw;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
